logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//   Registered, parametrised bitwise logic unit. Generalises the single-bit
//   NOT/AND/OR/XOR gate primitives to WIDTH-bit operands with a run-time
//   opcode and a valid/ready handshake on both sides. Adds an XOR accumulator
//   for running checksums and a count of accepted beats. Sits between
//   datapath stages that need registered bitwise ops with back-pressure.
// PARAMETERS
//   WIDTH   8   operand, result and accumulator width in bits (>=1)
//   CNT_W   8   width of the accepted-beat counter (>=1)
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        a/b/op/acc_clr are valid this cycle
//   in_ready   out  1        unit can accept a beat this cycle
//   op         in   3        opcode, see BEHAVIOUR
//   a          in   WIDTH    operand A
//   b          in   WIDTH    operand B (ignored for op 0)
//   acc_clr    in   1        clear accumulator; takes effect only on an accepted beat
//   out_valid  out  1        y/parity hold a result
//   out_ready  in   1        downstream takes the result this cycle
//   y          out  WIDTH    registered result
//   parity     out  1        XOR-reduction of y, registered with y
//   acc        out  WIDTH    accumulator value
//   beat_cnt   out  CNT_W    number of accepted input beats, modulo 2^CNT_W
// BEHAVIOUR
//   - Reset (rst_n=0, async): out_valid=0, y=0, parity=0, acc=0, beat_cnt=0.
//     in_ready is 1 immediately after reset.
//   - Accept: accept = in_valid & in_ready. Beats with in_valid=0 have no effect.
//   - in_ready = ~out_valid | out_ready. The ready path is combinational from
//     out_ready and adds no bubble, so full throughput is one beat per clock.
//   - Opcodes (bitwise over WIDTH):
//       0 NOT a   1 AND   2 OR    3 XOR
//       4 NAND    5 NOR   6 XNOR  7 XACC
//   - XACC: acc_next = acc_base ^ a ^ b, and y = acc_next.
//     acc_base = 0 if acc_clr is high on the same beat, otherwise acc_base = acc.
//   - On any accepted non-XACC beat with acc_clr=1: acc <= 0, and y is the normal
//     op result. On an accepted non-XACC beat with acc_clr=0, acc is unchanged.
//   - Latency is 1 clock. The result of the beat accepted at edge N appears on
//     y/parity with out_valid=1 after edge N.
//   - out_valid: set on accept. It clears on the edge where out_ready=1 and there
//     is no new accept. When out_ready=1 and a new beat is accepted on the same
//     edge, out_valid stays 1 and y is replaced.
//   - Stall (out_valid=1, out_ready=0): y, parity and acc hold; in_ready=0.
//   - beat_cnt increments by 1 on every accept and wraps from 2^CNT_W-1 to 0.
//   - y/parity are not updated when there is no accept. acc changes only on accept.
//   - Reset asserted mid-stall discards the pending result; no output is produced
//     for it after reset is released.
//   - No X propagation: op is fully decoded, so every opcode 0..7 is defined.
// TESTING
//   1 reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, y=0, acc=0,
//     beat_cnt=0 asynchronously. in_ready=1 after release.
//   2 ops: WIDTH=8, a=8'hA5, b=8'h3C, out_ready=1. Opcodes 0..6 give
//     y = 5A, 24, BD, 99, DB, 42, 66, each 1 cycle after accept; parity matches ^y.
//   3 XACC: acc_clr=1 with (a=0F,b=00), then (a=F0,b=00), then (a=FF,b=0F)
//     -> y/acc = 0F, FF, 0F. acc_clr=1 with op 7, a=01, b=02 -> acc=03.
//   4 back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0,
//     y held, beat_cnt +1 only. Release out_ready -> the next beat is accepted
//     on the same edge with no bubble.
//   5 throughput: 10 back-to-back beats with out_ready=1 -> 10 results on
//     10 consecutive cycles, beat_cnt=10.
//   6 wrap: CNT_W=2, 5 accepts -> beat_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Handshake bus for logic_unit_pipe: input beat (a/b/op/acc_clr) and registered result side.
// The unit itself connects through the slave modport.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             parity;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        output in_valid, op, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, y, parity, acc, beat_cnt
    );

    modport slave (
        input  in_valid, op, a, b, acc_clr, out_ready,
        output in_ready, out_valid, y, parity, acc, beat_cnt
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready on both sides,
// an XOR checksum accumulator and an accepted-beat counter.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    logic_unit_pipe_if.slave    bus
);
    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_XACC = 3'd7;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_result;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_parity;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_beat_cnt;

    // Ready looks straight through to out_ready so a draining result never costs a bubble.
    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;

    always_comb begin
        w_acc_base = bus.acc_clr ? '0 : r_acc;
        w_result   = '0;
        case (bus.op)
            OP_NOT:  w_result = ~bus.a;
            OP_AND:  w_result = bus.a & bus.b;
            OP_OR:   w_result = bus.a | bus.b;
            OP_XOR:  w_result = bus.a ^ bus.b;
            OP_NAND: w_result = ~(bus.a & bus.b);
            OP_NOR:  w_result = ~(bus.a | bus.b);
            OP_XNOR: w_result = ~(bus.a ^ bus.b);
            OP_XACC: w_result = w_acc_base ^ bus.a ^ bus.b;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_parity    <= 1'b0;
            r_acc       <= '0;
            r_beat_cnt  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_y         <= w_result;
            r_parity    <= ^w_result;
            r_beat_cnt  <= r_beat_cnt + CNT_W'(1);
            if (bus.op == OP_XACC) begin
                r_acc <= w_result;
            end else if (bus.acc_clr) begin
                r_acc <= '0;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.parity    = r_parity;
    assign bus.acc       = r_acc;
    assign bus.beat_cnt  = r_beat_cnt;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: opcodes, XACC, back-pressure, throughput,
// async reset mid-stall, and counter wrap on a CNT_W=2 instance.
`timescale 1ns/1ps
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(8)) bus_a ();
    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(2)) bus_b ();

    logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_ops [7];
    logic [7:0] e;

    initial begin
        exp_ops = '{8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66};
        rst_n = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.op = 3'd0; bus_a.a = '0; bus_a.b = '0;
        bus_a.acc_clr = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.op = 3'd0; bus_b.a = '0; bus_b.b = '0;
        bus_b.acc_clr = 1'b0; bus_b.out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_y", 32'(bus_a.y), 32'h0);
        chk("rst_acc", 32'(bus_a.acc), 32'h0);
        chk("rst_cnt", 32'(bus_a.beat_cnt), 32'd0);
        chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Opcodes 0..6 on A5/3C, one result per clock.
        bus_a.in_valid = 1'b1; bus_a.a = 8'hA5; bus_a.b = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            bus_a.op = 3'(i);
            tick();
            e = exp_ops[i];
            chk($sformatf("op%0d_y", i), 32'(bus_a.y), 32'(e));
            chk($sformatf("op%0d_par", i), 32'(bus_a.parity), 32'(^e));
            chk($sformatf("op%0d_vld", i), 32'(bus_a.out_valid), 32'd1);
        end
        chk("ops_cnt", 32'(bus_a.beat_cnt), 32'd7);

        // XACC running checksum
        bus_a.op = 3'd7; bus_a.acc_clr = 1'b1; bus_a.a = 8'h0F; bus_a.b = 8'h00;
        tick();
        chk("xacc1_y", 32'(bus_a.y), 32'h0F);
        chk("xacc1_acc", 32'(bus_a.acc), 32'h0F);
        bus_a.acc_clr = 1'b0; bus_a.a = 8'hF0;
        tick();
        chk("xacc2_y", 32'(bus_a.y), 32'hFF);
        chk("xacc2_acc", 32'(bus_a.acc), 32'hFF);
        bus_a.a = 8'hFF; bus_a.b = 8'h0F;
        tick();
        chk("xacc3_y", 32'(bus_a.y), 32'h0F);
        chk("xacc3_acc", 32'(bus_a.acc), 32'h0F);
        bus_a.acc_clr = 1'b1; bus_a.a = 8'h01; bus_a.b = 8'h02;
        tick();
        chk("xacc4_acc", 32'(bus_a.acc), 32'h03);
        chk("xacc4_par", 32'(bus_a.parity), 32'd0);

        // Non-XACC beats: acc held without clear, zeroed with clear
        bus_a.op = 3'd1; bus_a.acc_clr = 1'b0; bus_a.a = 8'hA5; bus_a.b = 8'h3C;
        tick();
        chk("and_hold_y", 32'(bus_a.y), 32'h24);
        chk("and_hold_acc", 32'(bus_a.acc), 32'h03);
        bus_a.acc_clr = 1'b1;
        tick();
        chk("and_clr_y", 32'(bus_a.y), 32'h24);
        chk("and_clr_acc", 32'(bus_a.acc), 32'h00);
        chk("and_clr_cnt", 32'(bus_a.beat_cnt), 32'd13);

        // Drain: out_valid drops with no new beat, y holds
        bus_a.in_valid = 1'b0; bus_a.acc_clr = 1'b0;
        tick();
        chk("drain_vld", 32'(bus_a.out_valid), 32'd0);
        chk("drain_y", 32'(bus_a.y), 32'h24);

        // Back-pressure
        bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1;
        bus_a.op = 3'd2; bus_a.a = 8'h0F; bus_a.b = 8'hF0;
        tick();
        chk("bp_first_y", 32'(bus_a.y), 32'hFF);
        bus_a.a = 8'h00; bus_a.b = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp%0d_rdy", i), 32'(bus_a.in_ready), 32'd0);
            chk($sformatf("bp%0d_y", i), 32'(bus_a.y), 32'hFF);
            chk($sformatf("bp%0d_vld", i), 32'(bus_a.out_valid), 32'd1);
            chk($sformatf("bp%0d_cnt", i), 32'(bus_a.beat_cnt), 32'd14);
        end
        bus_a.out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(bus_a.in_ready), 32'd1);
        tick();
        chk("bp_rel_y", 32'(bus_a.y), 32'h00);
        chk("bp_rel_vld", 32'(bus_a.out_valid), 32'd1);
        chk("bp_rel_cnt", 32'(bus_a.beat_cnt), 32'd15);

        // Throughput: 10 back-to-back beats
        bus_a.op = 3'd3; bus_a.b = 8'h10;
        for (int i = 0; i < 10; i++) begin
            bus_a.a = 8'(i);
            tick();
            chk($sformatf("tp%0d_y", i), 32'(bus_a.y), 32'(8'(i) ^ 8'h10));
            chk($sformatf("tp%0d_vld", i), 32'(bus_a.out_valid), 32'd1);
        end
        chk("tp_cnt", 32'(bus_a.beat_cnt), 32'd25);
        bus_a.in_valid = 1'b0;
        tick();
        chk("tp_end_vld", 32'(bus_a.out_valid), 32'd0);

        // Async reset during a stall discards the pending result
        bus_a.in_valid = 1'b1; bus_a.op = 3'd7; bus_a.acc_clr = 1'b1;
        bus_a.a = 8'h55; bus_a.b = 8'h00; bus_a.out_ready = 1'b0;
        tick();
        chk("pre_rst_acc", 32'(bus_a.acc), 32'h55);
        tick();
        chk("pre_rst_vld", 32'(bus_a.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(bus_a.out_valid), 32'd0);
        chk("arst_y", 32'(bus_a.y), 32'h0);
        chk("arst_acc", 32'(bus_a.acc), 32'h0);
        chk("arst_cnt", 32'(bus_a.beat_cnt), 32'd0);
        bus_a.in_valid = 1'b0; bus_a.acc_clr = 1'b0; bus_a.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("post_rst_rdy", 32'(bus_a.in_ready), 32'd1);
        repeat (2) tick();
        chk("post_rst_vld", 32'(bus_a.out_valid), 32'd0);
        chk("post_rst_cnt", 32'(bus_a.beat_cnt), 32'd0);

        // Counter wrap on CNT_W=2
        bus_b.in_valid = 1'b1; bus_b.op = 3'd3; bus_b.a = 8'h11; bus_b.b = 8'h22;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("wrap%0d_cnt", i), 32'(bus_b.beat_cnt), 32'((i + 1) % 4));
        end
        chk("wrap_y", 32'(bus_b.y), 32'h33);
        bus_b.in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
